// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding, drawer indices and frame constants for the draw scheduler
package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_DRAW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Drawer indices; a higher index wins arbitration.
  localparam logic [1:0] SRC_TITLE  = 2'd0;
  localparam logic [1:0] SRC_BATTLE = 2'd1;
  localparam logic [1:0] SRC_WIN    = 2'd2;
  localparam logic [1:0] SRC_LOSE   = 2'd3;

  localparam int DEF_SCR_W  = 320;
  localparam int DEF_SCR_H  = 240;
  localparam int LAST_PIXEL = DEF_SCR_W * DEF_SCR_H - 1;

  // Watchdog width: holds a full 320x240 frame plus slack.
  localparam int WD_W = 17;

endpackage

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - drawer-side and VGA-side signal bundle of the draw scheduler
interface draw_scheduler_if #(
  parameter int NUM_SRC = 4
);

  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   src_done;
  logic [NUM_SRC*9-1:0] src_x;
  logic [NUM_SRC*8-1:0] src_y;
  logic [NUM_SRC*3-1:0] src_colour;
  logic [NUM_SRC-1:0]   src_enable;
  logic [NUM_SRC-1:0]   src_reset_n;
  logic [8:0]           vga_x;
  logic [7:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 frame_done;

  // Scheduler side.
  modport slave (
    input  req, src_done, src_x, src_y, src_colour,
    output src_enable, src_reset_n, vga_x, vga_y, vga_colour, vga_plot,
    output busy, grant_id, frame_done
  );

  // Drawers / VGA adapter / controller side.
  modport master (
    output req, src_done, src_x, src_y, src_colour,
    input  src_enable, src_reset_n, vga_x, vga_y, vga_colour, vga_plot,
    input  busy, grant_id, frame_done
  );

endinterface

// File: rtl/draw_priority_pick.sv
// rtl/draw_priority_pick.sv - highest-index-first encoder over the pending request vector
module draw_priority_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] pending_i,
  output logic [1:0]         index_o,
  output logic               valid_o
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_i[i]) begin
        index_o = 2'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - arbitrates full-screen drawers onto the single VGA write port
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240
) (
  input  logic           clock_all,
  input  logic           reset_all,
  draw_scheduler_if.slave bus
);

  // Last cycle index a DRAW may reach without src_done before being forced out.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(SCR_W * SCR_H + 1);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d, grant_clr;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           pick_idx;
  logic                 pick_valid;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [8:0]           vga_x_q, sel_x;
  logic [7:0]           vga_y_q, sel_y;
  logic [2:0]           sel_colour;
  logic                 plot_q;
  logic                 sel_done;
  logic [NUM_SRC-1:0]   sel_onehot;

  draw_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .pending_i (pending_q),
    .index_o   (pick_idx),
    .valid_o   (pick_valid)
  );

  // Route the granted drawer's coordinates, colour and done flag.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_done   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 2'(i)) begin
        sel_x         = bus.src_x[i*9 +: 9];
        sel_y         = bus.src_y[i*8 +: 8];
        sel_colour    = bus.src_colour[i*3 +: 3];
        sel_done      = bus.src_done[i];
        sel_onehot[i] = (state_q == ST_DRAW);
      end
    end
  end

  // Next state, grant capture, pending update and DRAW watchdog.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grant_clr = '0;
    wd_d      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_CLEAR;
          grant_d = pick_idx;
          for (int i = 0; i < NUM_SRC; i++) begin
            grant_clr[i] = (pick_idx == 2'(i));
          end
        end
      end
      ST_CLEAR: state_d = ST_DRAW;
      ST_DRAW: begin
        wd_d = wd_q + WD_W'(1);
        if (sel_done || (wd_q == WD_LIMIT)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A request in the grant cycle re-arms its bit so it is not lost.
    pending_d = (pending_q & ~grant_clr) | bus.req;
  end

  // Control state registers.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      wd_q      <= wd_d;
    end
  end

  // Coordinates and plot strobe delayed one cycle to meet the ROM colour.
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      vga_x_q <= '0;
      vga_y_q <= '0;
      plot_q  <= 1'b0;
    end else begin
      vga_x_q <= sel_x;
      vga_y_q <= sel_y;
      plot_q  <= (state_q == ST_DRAW);
    end
  end

  assign bus.src_enable  = sel_onehot;
  assign bus.src_reset_n = sel_onehot;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = sel_colour;
  assign bus.vga_plot    = plot_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.frame_done  = (state_q == ST_FIN);

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler with model drawers on a reduced screen
module tb_draw_scheduler;

  localparam int NS   = 4;
  localparam int W    = 20;
  localparam int H    = 12;
  localparam int NPIX = W * H;

  logic clock_all;
  logic reset_all;

  draw_scheduler_if #(.NUM_SRC(NS)) bus ();

  draw_scheduler #(.NUM_SRC(NS), .SCR_W(W), .SCR_H(H)) dut (
    .clock_all (clock_all),
    .reset_all (reset_all),
    .bus       (bus)
  );

  initial clock_all = 1'b0;
  always #5 clock_all = ~clock_all;

  int   n_total = 0;
  int   n_pass  = 0;

  // Model drawers: row-major counter with sync active-low reset, ROM colour one cycle late.
  int       cnt [NS];
  logic [2:0] col_q [NS];
  bit       hold_done = 1'b0;
  bit       tog_en    = 1'b0;
  logic     tog1      = 1'b0;

  always @(posedge clock_all) begin
    for (int i = 0; i < NS; i++) begin
      col_q[i] <= 3'((cnt[i] % W + cnt[i] / W + i) % 8);
      if (!bus.src_reset_n[i]) cnt[i] <= 0;
      else if (bus.src_enable[i] && cnt[i] != NPIX - 1) cnt[i] <= cnt[i] + 1;
    end
    tog1 <= tog_en ? ~tog1 : 1'b0;
  end

  always @* begin
    for (int i = 0; i < NS; i++) begin
      bus.src_x[i*9 +: 9]      = 9'(cnt[i] % W);
      bus.src_y[i*8 +: 8]      = 8'(cnt[i] / W);
      bus.src_colour[i*3 +: 3] = col_q[i];
      bus.src_done[i]          = !hold_done && (cnt[i] == NPIX - 1);
    end
    if (tog1) bus.src_done[1] = 1'b1;
  end

  // Scoreboard: expected grant order pushed by stimulus, one record per observed frame.
  typedef struct {
    int exp_g;
    int act_g;
    int plots;
    int errs;
    int align;
  } frame_t;

  frame_t done_q [$];
  int     exp_q  [$];
  int     pix_idx    = 0;
  int     pix_err    = 0;
  int     long_pulse = 0;
  logic   prev_fd    = 1'b0;
  logic   prev_plot  = 1'b0;

  always @(negedge clock_all) begin
    int e, ex, ey, g;
    frame_t f;
    if (reset_all) begin
      if (bus.vga_plot) begin
        e  = (pix_idx < NPIX) ? pix_idx : NPIX - 1;
        ex = e % W;
        ey = e / W;
        g  = (exp_q.size() > 0) ? exp_q[0] : 0;
        if (bus.vga_x !== 9'(ex) || bus.vga_y !== 8'(ey) ||
            bus.vga_colour !== 3'((ex + ey + g) % 8)) pix_err++;
        pix_idx++;
      end
      if (bus.frame_done && prev_fd) long_pulse++;
      if (bus.frame_done && !prev_fd) begin
        f.exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        f.act_g = int'(bus.grant_id);
        f.plots = pix_idx;
        f.errs  = pix_err;
        f.align = (prev_plot && !bus.vga_plot) ? 1 : 0;
        done_q.push_back(f);
        pix_idx = 0;
        pix_err = 0;
      end
    end
    prev_fd   = bus.frame_done;
    prev_plot = bus.vga_plot;
  end

  task automatic pulse_req(input logic [NS-1:0] r);
    @(negedge clock_all);
    bus.req = r;
    @(negedge clock_all);
    bus.req = '0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int c = 0;
    while (done_q.size() < n && c < budget) begin
      @(negedge clock_all);
      c++;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic test_reset();
    reset_all = 1'b0;
    bus.req   = '0;
    #12;
    n_total++; if (bus.vga_plot !== 1'b0) $display("FAIL rst_plot got %b want 0", bus.vga_plot); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.frame_done !== 1'b0) $display("FAIL rst_fdone got %b want 0", bus.frame_done); else n_pass++;
    n_total++; if (bus.src_enable !== 4'b0000) $display("FAIL rst_enable got %b want 0000", bus.src_enable); else n_pass++;
    n_total++; if (bus.src_reset_n !== 4'b0000) $display("FAIL rst_srcrst got %b want 0000", bus.src_reset_n); else n_pass++;
    n_total++; if (bus.grant_id !== 2'd0) $display("FAIL rst_grant got %0d want 0", bus.grant_id); else n_pass++;
    n_total++; if (bus.vga_x !== 9'd0 || bus.vga_y !== 8'd0) $display("FAIL rst_xy got %0d,%0d want 0,0", bus.vga_x, bus.vga_y); else n_pass++;
    @(negedge clock_all);
    reset_all = 1'b1;
    repeat (3) @(negedge clock_all);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    frame_t f;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    @(negedge clock_all);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got %b want 1", bus.busy); else n_pass++;
    n_total++; if (bus.src_reset_n !== 4'b0000) $display("FAIL single_clear_rstn got %b want 0000", bus.src_reset_n); else n_pass++;
    @(negedge clock_all);
    n_total++; if (bus.src_enable !== 4'b0001) $display("FAIL single_enable got %b want 0001", bus.src_enable); else n_pass++;
    wait_frames(1, NPIX + 50, ok);
    n_total++; if (!ok) $display("FAIL single_timeout got %0d frames want 1", done_q.size()); else n_pass++;
    repeat (2) @(negedge clock_all);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL single_idle got busy %b want 0", bus.busy); else n_pass++;
    while (done_q.size() > 0) begin
      f = done_q.pop_front();
      n_total++; if (f.act_g !== f.exp_g) $display("FAIL single_grant got %0d want %0d", f.act_g, f.exp_g); else n_pass++;
      n_total++; if (f.plots !== NPIX) $display("FAIL single_plots got %0d want %0d", f.plots, NPIX); else n_pass++;
      n_total++; if (f.errs !== 0) $display("FAIL single_pixels got %0d bad want 0", f.errs); else n_pass++;
      n_total++; if (f.align !== 1) $display("FAIL single_fdone_align got %0d want 1", f.align); else n_pass++;
    end
  endtask

  task automatic test_priority();
    bit ok;
    frame_t f;
    exp_q.push_back(2);
    exp_q.push_back(0);
    pulse_req(4'b0101);
    wait_frames(2, 3 * NPIX, ok);
    n_total++; if (!ok) $display("FAIL prio_timeout got %0d frames want 2", done_q.size()); else n_pass++;
    repeat (4) @(negedge clock_all);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL prio_idle got busy %b want 0", bus.busy); else n_pass++;
    n_total++; if (done_q.size() !== 2) $display("FAIL prio_frames got %0d want 2", done_q.size()); else n_pass++;
    while (done_q.size() > 0) begin
      f = done_q.pop_front();
      n_total++; if (f.act_g !== f.exp_g) $display("FAIL prio_grant got %0d want %0d", f.act_g, f.exp_g); else n_pass++;
      n_total++; if (f.plots !== NPIX) $display("FAIL prio_plots got %0d want %0d", f.plots, NPIX); else n_pass++;
      n_total++; if (f.errs !== 0) $display("FAIL prio_pixels got %0d bad want 0", f.errs); else n_pass++;
    end
  endtask

  task automatic test_redraw();
    bit ok;
    int c;
    frame_t f;
    exp_q.push_back(3);
    pulse_req(4'b1000);
    c = 0;
    while (pix_idx < NPIX / 2 && c < 2 * NPIX) begin
      @(negedge clock_all);
      c++;
    end
    exp_q.push_back(3);
    pulse_req(4'b1000);
    n_total++; if (bus.grant_id !== 2'd3) $display("FAIL redraw_hold got %0d want 3", bus.grant_id); else n_pass++;
    wait_frames(2, 3 * NPIX, ok);
    n_total++; if (!ok) $display("FAIL redraw_timeout got %0d frames want 2", done_q.size()); else n_pass++;
    repeat (4) @(negedge clock_all);
    n_total++; if (done_q.size() !== 2) $display("FAIL redraw_frames got %0d want 2", done_q.size()); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL redraw_idle got busy %b want 0", bus.busy); else n_pass++;
    while (done_q.size() > 0) begin
      f = done_q.pop_front();
      n_total++; if (f.act_g !== f.exp_g) $display("FAIL redraw_grant got %0d want %0d", f.act_g, f.exp_g); else n_pass++;
      n_total++; if (f.plots !== NPIX) $display("FAIL redraw_plots got %0d want %0d", f.plots, NPIX); else n_pass++;
      n_total++; if (f.errs !== 0) $display("FAIL redraw_pixels got %0d bad want 0", f.errs); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    c = 0;
    while (pix_idx < 100 && c < 2 * NPIX) begin
      @(negedge clock_all);
      c++;
    end
    pulse_req(4'b0100);
    #1;
    reset_all = 1'b0;
    #1;
    n_total++; if (bus.vga_plot !== 1'b0) $display("FAIL mid_plot got %b want 0", bus.vga_plot); else n_pass++;
    n_total++; if (bus.src_reset_n !== 4'b0000) $display("FAIL mid_srcrst got %b want 0000", bus.src_reset_n); else n_pass++;
    n_total++; if (bus.src_enable !== 4'b0000) $display("FAIL mid_enable got %b want 0000", bus.src_enable); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) $display("FAIL mid_busy got %b/%b want 0/0", bus.busy, bus.frame_done); else n_pass++;
    n_total++; if (bus.vga_x !== 9'd0 || bus.vga_y !== 8'd0 || bus.grant_id !== 2'd0) $display("FAIL mid_regs got %0d,%0d,%0d want 0,0,0", bus.vga_x, bus.vga_y, bus.grant_id); else n_pass++;
    exp_q.delete();
    pix_idx = 0;
    pix_err = 0;
    @(negedge clock_all);
    reset_all = 1'b1;
    repeat (3 * NPIX) @(negedge clock_all);
    n_total++; if (done_q.size() !== 0) $display("FAIL mid_no_frame got %0d frames want 0", done_q.size()); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_dropped got busy %b want 0", bus.busy); else n_pass++;
    done_q.delete();
  endtask

  task automatic test_watchdog();
    bit ok;
    frame_t f;
    hold_done = 1'b1;
    exp_q.push_back(1);
    pulse_req(4'b0010);
    wait_frames(1, 3 * NPIX, ok);
    hold_done = 1'b0;
    n_total++; if (!ok) $display("FAIL wd_timeout got %0d frames want 1", done_q.size()); else n_pass++;
    repeat (2) @(negedge clock_all);
    while (done_q.size() > 0) begin
      f = done_q.pop_front();
      n_total++; if (f.act_g !== f.exp_g) $display("FAIL wd_grant got %0d want %0d", f.act_g, f.exp_g); else n_pass++;
      n_total++; if (f.plots !== NPIX + 2) $display("FAIL wd_plots got %0d want %0d", f.plots, NPIX + 2); else n_pass++;
      n_total++; if (f.errs !== 0) $display("FAIL wd_pixels got %0d bad want 0", f.errs); else n_pass++;
    end
  endtask

  task automatic test_foreign_done();
    bit ok;
    frame_t f;
    tog_en = 1'b1;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    wait_frames(1, 2 * NPIX, ok);
    tog_en = 1'b0;
    n_total++; if (!ok) $display("FAIL foreign_timeout got %0d frames want 1", done_q.size()); else n_pass++;
    repeat (3) @(negedge clock_all);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL foreign_idle got busy %b want 0", bus.busy); else n_pass++;
    while (done_q.size() > 0) begin
      f = done_q.pop_front();
      n_total++; if (f.act_g !== f.exp_g) $display("FAIL foreign_grant got %0d want %0d", f.act_g, f.exp_g); else n_pass++;
      n_total++; if (f.plots !== NPIX) $display("FAIL foreign_plots got %0d want %0d", f.plots, NPIX); else n_pass++;
      n_total++; if (f.errs !== 0) $display("FAIL foreign_pixels got %0d bad want 0", f.errs); else n_pass++;
    end
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_single();
    test_priority();
    test_redraw();
    test_reset_mid();
    test_watchdog();
    test_foreign_done();
    n_total++; if (long_pulse !== 0) $display("FAIL fdone_width got %0d long pulses want 0", long_pulse); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning number of full-screen drawers sharing the VGA write port (0 title, 1 battle, 2 win, 3 lose).
REQ-002 The block SHALL have parameter SCR_W, default 320, meaning screen width in pixels.
REQ-003 The block SHALL have parameter SCR_H, default 240, meaning screen height in pixels.
REQ-004 The block SHALL have port clock_all, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_all, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NUM_SRC bits: one-cycle draw-request pulses, one bit per drawer.
REQ-007 The block SHALL have port src_done, input, NUM_SRC bits: each drawer's done flag (high while its counter sits on the last pixel).
REQ-008 The block SHALL have port src_x, input, NUM_SRC*9 bits: packed drawer x coordinates.
REQ-009 The block SHALL have port src_y, input, NUM_SRC*8 bits: packed drawer y coordinates.
REQ-010 The block SHALL have port src_colour, input, NUM_SRC*3 bits: packed drawer colours, registered ROM data lagging x/y by one cycle.
REQ-011 The block SHALL have port src_enable, output, NUM_SRC bits: drawer enables.
REQ-012 The block SHALL have port src_reset_n, output, NUM_SRC bits: drawer active-low synchronous resets.
REQ-013 The block SHALL have ports vga_x (output, 9 bits), vga_y (output, 8 bits), vga_colour (output, 3 bits) and vga_plot (output, 1 bit): the VGA adapter write port.
REQ-014 The block SHALL have ports busy (output, 1 bit), grant_id (output, 2 bits) and frame_done (output, 1 bit, one-cycle pulse).

Function
REQ-015 The block SHALL set pending[i] on req[i]=1, and SHALL clear pending[i] only on the cycle drawer i is granted.
- A req[i] arriving while i is being drawn SHALL re-set pending[i] so that i is redrawn afterwards.
REQ-016 The state machine SHALL have the states IDLE, CLEAR, DRAW, FLUSH and FIN, with these transitions:
- IDLE to CLEAR when any pending bit is set; grant goes to the highest set index (lose > win > battle > title).
- CLEAR to DRAW after exactly 1 cycle.
- DRAW to FLUSH in the cycle src_done[grant]=1.
- FLUSH to FIN after 1 cycle.
- FIN to IDLE after 1 cycle.
REQ-017 src_reset_n[i] SHALL be 1 only when state=DRAW and grant_id=i; otherwise it SHALL be 0, so every drawer starts at pixel (0,0).
REQ-018 src_enable[i] SHALL be 1 only when state=DRAW and grant_id=i.
REQ-019 vga_x and vga_y SHALL be the granted src_x and src_y registered by one cycle; vga_colour SHALL be the granted src_colour, passed without added delay; the result aligns coordinates with the ROM latency.
REQ-020 vga_plot SHALL be (state=DRAW) registered by one cycle, giving exactly SCR_W*SCR_H plots per frame with the last plot in FLUSH.
REQ-021 frame_done SHALL pulse high for exactly the one FIN cycle.
REQ-022 busy SHALL be 1 in every state other than IDLE.
REQ-023 grant_id SHALL hold its value from the CLEAR state through the FIN state.
REQ-024 Requests arriving during CLEAR, DRAW, FLUSH or FIN SHALL NOT preempt the current frame; they are served from IDLE by priority.
REQ-025 A src_done[j] with j different from grant_id SHALL be ignored.
REQ-026 The block SHALL include a watchdog: if DRAW lasts SCR_W*SCR_H+2 cycles without src_done, the FSM SHALL go to FLUSH (17-bit counter).

Reset
REQ-027 While reset_all=0 the block SHALL be asynchronously in this state:
- state IDLE, pending=0, grant_id=0.
- src_enable=0, src_reset_n=0.
- vga_x=0, vga_y=0, vga_plot=0.
- busy=0, frame_done=0, watchdog=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further plots, and SHALL drop all pending requests.

Structure
REQ-029 The state encoding, the source indices and the constant LAST_PIXEL=SCR_W*SCR_H-1 SHALL live in shared package draw_pkg.
REQ-030 The block SHALL contain one sub-module, draw_priority_pick: a combinational highest-index-first encoder over pending, with outputs index and valid.

Verification
REQ-031 Scenario: req=0001 with a model drawer -> exactly 76800 plots, vga_x/vga_y sweep (0,0) to (319,239) row-major, frame_done 1 cycle after the last plot, busy=0 afterwards.
REQ-032 Scenario: req=0101 in the same cycle -> drawer 2 is drawn first, then drawer 0; two frame_done pulses; grant_id sequence 2 then 0.
REQ-033 Scenario: req[3] pulsed mid-frame while drawer 3 is drawing -> the frame completes, then drawer 3 is redrawn once.
REQ-034 Scenario: reset_all=0 at pixel 1000 -> vga_plot=0 immediately, all outputs at reset values, no frame_done, src_reset_n=0000.
REQ-035 Scenario: drawer never raises src_done -> watchdog forces FLUSH after 76802 DRAW cycles; frame_done still pulses.
REQ-036 Scenario: src_done[1] toggled while drawer 0 is drawing -> no effect on state; plot count stays 76800.
